fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
// Owner keeps the port until last beat, BURST_MAX beats, or a stall timeout.
module fifo_wr_arbiter #(
  parameter int DATASIZE  = 8,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                     wr_clk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_full,
  output logic                     wr_en,
  output logic [DATASIZE-1:0]      wdata,
  output logic [NREQ-1:0]          grant,
  output logic                     abort_err
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int BW = 5;
  localparam int SW = 8;

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     own_q, own_d;
  logic [IW-1:0]     last_q, last_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic              abort_q, abort_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [IW:0]       cand;
  logic [DATASIZE-1:0] data_arr [NREQ];
  logic              in_burst;
  logic              own_valid;
  logic              own_last;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*DATASIZE +: DATASIZE];
    end
  end

  assign in_burst  = (state_q == BURST);
  assign own_valid = req_valid[own_q];
  assign own_last  = req_last[own_q];

  // Outputs are combinational off the state so an async reset drops them at once
  assign wr_en     = in_burst && own_valid && !wr_full;
  assign req_ready = (in_burst && !wr_full) ? grant_q : '0;
  assign wdata     = in_burst ? data_arr[own_q] : '0;
  assign grant     = grant_q;
  assign abort_err = abort_q;

  // Search starts just after the previous owner, wrapping back to it last
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!pick_found && req_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    last_d  = last_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          own_d   = pick_idx;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      BURST: begin
        if (wr_en) begin
          stall_d = '0;
          beat_d  = beat_q + 1'b1;
          if (own_last || beat_q == BW'(BURST_MAX-1)) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = own_q;
            beat_d  = '0;
          end
        end else if (!wr_full && !own_valid) begin
          if (stall_q == SW'(TIMEOUT-1)) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = own_q;
            beat_d  = '0;
            stall_d = '0;
            abort_d = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      last_q  <= IW'(NREQ-1);
      beat_q  <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

endmodule
